// File: rtl/regfile_arbiter.sv
// Round-robin two-requester arbiter/sequencer in front of the configuration register file.
// Optional build macro REGFILE_ARB_LOCK_EN adds cfg_lock, a write-protect for requester 0.
module regfile_arbiter #(
  parameter int NUMREGS = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_write,
  input  logic [7:0] req_addr  [0:1],
  input  logic [7:0] req_wdata [0:1],
  output logic [1:0] req_ready,
  output logic [1:0] rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       rf_write,
  output logic [7:0] rf_write_addr,
  output logic [7:0] rf_write_data,
  output logic       rf_read,
  output logic [7:0] rf_read_addr,
  input  logic [7:0] rf_read_data
`ifdef REGFILE_ARB_LOCK_EN
  ,
  input  logic       cfg_lock
`endif
);

  // Handshake: a requester holds req_valid and its fields stable until it sees
  // req_ready (a one-cycle grant pulse); rsp_valid is a pulse with no backpressure.

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [8:0] ADDR_LIM = 9'(NUMREGS);

  state_t     state_q;
  state_t     state_d;
  logic       ptr_q;
  logic       cap_write;
  logic [7:0] cap_addr;
  logic [7:0] cap_wdata;
  logic       cap_id;
  logic       cap_err;
  logic [7:0] rdata_q;

  logic       grant_id;
  logic       grant_fire;
  logic       in_range;
  logic       lock_hit;

  // Preferred requester wins a tie; a lone requester always wins.
  always_comb begin
    if (req_valid == 2'b11) begin
      grant_id = ptr_q;
    end else begin
      grant_id = ~req_valid[0];
    end
    grant_fire = reset_n && (state_q == S_IDLE) && (|req_valid);
    in_range   = {1'b0, req_addr[grant_id]} < ADDR_LIM;
`ifdef REGFILE_ARB_LOCK_EN
    lock_hit   = (grant_id == 1'b0) && req_write[0] && cfg_lock;
`else
    lock_hit   = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= 1'b0;
      cap_write <= 1'b0;
      cap_addr  <= 8'd0;
      cap_wdata <= 8'd0;
      cap_id    <= 1'b0;
      cap_err   <= 1'b0;
      rdata_q   <= 8'd0;
    end else begin
      if (grant_fire) begin
        cap_write <= req_write[grant_id];
        cap_addr  <= req_addr[grant_id];
        cap_wdata <= req_wdata[grant_id];
        cap_id    <= grant_id;
        cap_err   <= !in_range || lock_hit;
        ptr_q     <= ~grant_id;
      end
      if (state_q == S_RDWAIT) begin
        rdata_q <= rf_read_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_fire) state_d = S_ISSUE;
      S_ISSUE:  state_d = (!cap_err && !cap_write) ? S_RDWAIT : S_RESP;
      S_RDWAIT: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes and response are decoded only from state and captured registers.
  always_comb begin
    req_ready     = 2'b00;
    rsp_valid     = 2'b00;
    rsp_rdata     = 8'd0;
    rsp_err       = 1'b0;
    rf_write      = 1'b0;
    rf_write_addr = 8'd0;
    rf_write_data = 8'd0;
    rf_read       = 1'b0;
    rf_read_addr  = 8'd0;
    case (state_q)
      S_IDLE: begin
        if (grant_fire) req_ready[grant_id] = 1'b1;
      end
      S_ISSUE: begin
        if (!cap_err) begin
          if (cap_write) begin
            rf_write      = 1'b1;
            rf_write_addr = cap_addr;
            rf_write_data = cap_wdata;
          end else begin
            rf_read      = 1'b1;
            rf_read_addr = cap_addr;
          end
        end
      end
      S_RESP: begin
        rsp_valid[cap_id] = 1'b1;
        rsp_err           = cap_err;
        if (!cap_err && !cap_write) rsp_rdata = rdata_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter: transaction-level reference model, regfile stub,
// directed scenarios and randomized two-requester traffic.
module tb_regfile_arbiter;

  localparam int NUMREGS = 6;

  logic       clk;
  logic       reset_n;
  logic [1:0] req_valid;
  logic [1:0] req_write;
  logic [7:0] req_addr  [0:1];
  logic [7:0] req_wdata [0:1];
  logic [1:0] req_ready;
  logic [1:0] rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rf_write;
  logic [7:0] rf_write_addr;
  logic [7:0] rf_write_data;
  logic       rf_read;
  logic [7:0] rf_read_addr;
  logic [7:0] rf_read_data;
  logic       cfg_lock;

  logic       v0, v1, w0, w1;
  logic [7:0] a0, a1, d0, d1;

  assign req_valid    = {v1, v0};
  assign req_write    = {w1, w0};
  assign req_addr[0]  = a0;
  assign req_addr[1]  = a1;
  assign req_wdata[0] = d0;
  assign req_wdata[1] = d1;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  regfile_arbiter #(.NUMREGS(NUMREGS)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .rf_write      (rf_write),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_read       (rf_read),
    .rf_read_addr  (rf_read_addr),
    .rf_read_data  (rf_read_data)
`ifdef REGFILE_ARB_LOCK_EN
    ,
    .cfg_lock      (cfg_lock)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // regfile stub: 1-cycle registered read
  logic [7:0] stub_mem [256];
  always @(posedge clk) begin
    if (rf_write) stub_mem[rf_write_addr] <= rf_write_data;
    if (rf_read)  rf_read_data <= stub_mem[rf_read_addr];
  end

  // reference model, evaluated at each negedge with the inputs the DUT will sample
  logic [7:0]  ref_mem [256];
  logic [25:0] rsp_q  [$];   // {cycle[15:0], id, err, rdata}
  logic [32:0] strb_q [$];   // {cycle[15:0], write, addr, data}
  logic [1:0]  exp_ready;
  int          ptr_m    = 0;
  int          free_cyc = 0;

  always @(negedge clk) begin
    int g, rc;
    logic w, e, lk;
    logic [7:0] a, d, rd;
    if (!reset_n) begin
      rsp_q.delete();
      strb_q.delete();
      ptr_m     = 0;
      free_cyc  = 0;
      exp_ready = 2'b00;
    end else begin
      exp_ready = 2'b00;
      if (cyc >= free_cyc && req_valid != 2'b00) begin
        if (req_valid == 2'b11) g = ptr_m;
        else g = req_valid[0] ? 0 : 1;
        exp_ready[g] = 1'b1;
        ptr_m = 1 - g;
        w = req_write[g];
        a = req_addr[g];
        d = req_wdata[g];
`ifdef REGFILE_ARB_LOCK_EN
        lk = (g == 0) && w && cfg_lock;
`else
        lk = 1'b0;
`endif
        e = (int'(a) >= NUMREGS) || lk;
        rd = 8'h00;
        rc = cyc + 2;
        if (!e) begin
          strb_q.push_back({16'(cyc + 1), w, a, w ? d : 8'h00});
          if (w) ref_mem[a] = d;
          else begin
            rd = ref_mem[a];
            rc = cyc + 3;
          end
        end
        rsp_q.push_back({16'(rc), 1'(g), e, rd});
        free_cyc = rc + 1;
      end
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [32:0] es;
    logic [25:0] er;
    logic [1:0]  ev;
    #1;
    if (!reset_n) begin
      checks++;
      if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rf_write, rf_write_addr,
           rf_write_data, rf_read, rf_read_addr} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d ready=%b rsp_valid=%b rf_write=%b rf_read=%b", cyc,
                 req_ready, rsp_valid, rf_write, rf_read);
      end
    end else begin
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, exp_ready);
      end
      if (rf_write || rf_read) begin
        checks++;
        if (strb_q.size() == 0 || strb_q[0][32:17] != 16'(cyc)) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d wr=%b rd=%b", cyc, rf_write, rf_read);
        end else begin
          es = strb_q.pop_front();
          if ((rf_write && rf_read) || rf_write !== es[16] ||
              (rf_write ? rf_write_addr : rf_read_addr) !== es[15:8] ||
              (rf_write ? rf_write_data : 8'h00) !== es[7:0]) begin
            errors++;
            $display("FAIL strobe cyc=%0d got wr=%b rd=%b waddr=%h wdata=%h raddr=%h exp wr=%b addr=%h data=%h",
                     cyc, rf_write, rf_read, rf_write_addr, rf_write_data, rf_read_addr,
                     es[16], es[15:8], es[7:0]);
          end
        end
      end else if (strb_q.size() > 0 && strb_q[0][32:17] <= 16'(cyc)) begin
        checks++;
        errors++;
        es = strb_q.pop_front();
        $display("FAIL missing_strobe cyc=%0d exp wr=%b addr=%h", cyc, es[16], es[15:8]);
      end
      if (rsp_valid != 2'b00) begin
        checks++;
        if (rsp_q.size() == 0 || rsp_q[0][25:10] != 16'(cyc)) begin
          errors++;
          $display("FAIL unexpected_rsp cyc=%0d rsp_valid=%b", cyc, rsp_valid);
        end else begin
          er = rsp_q.pop_front();
          ev = er[9] ? 2'b10 : 2'b01;
          if (rsp_valid !== ev || rsp_err !== er[8] || rsp_rdata !== er[7:0]) begin
            errors++;
            $display("FAIL rsp cyc=%0d got valid=%b err=%b rdata=%h exp valid=%b err=%b rdata=%h",
                     cyc, rsp_valid, rsp_err, rsp_rdata, ev, er[8], er[7:0]);
          end
        end
      end else if (rsp_q.size() > 0 && rsp_q[0][25:10] <= 16'(cyc)) begin
        checks++;
        errors++;
        er = rsp_q.pop_front();
        $display("FAIL missing_rsp cyc=%0d exp id=%0d", cyc, er[9]);
      end
    end
  end

  // driver
  task automatic issue(input int id, input logic w, input logic [7:0] a, input logic [7:0] d);
    int  n   = 0;
    bit  got = 0;
    if (id == 0) begin v0 = 1'b1; w0 = w; a0 = a; d0 = d; end
    else         begin v1 = 1'b1; w1 = w; a1 = a; d1 = d; end
    while (!got && n < 100) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
      n++;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL handshake_timeout id=%0d got=0 exp=1", id);
    end
    @(posedge clk);
    #1;
    if (id == 0) v0 = 1'b0;
    else         v1 = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic random_traffic(input int id, input int count);
    logic [7:0] a;
    for (int k = 0; k < count; k++) begin
      idle_cycles(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) a = 8'($urandom_range(6, 255));
      else a = 8'($urandom_range(0, 6));
      issue(id, 1'($urandom_range(0, 1)), a, 8'($urandom));
    end
  endtask

  initial begin
    logic [7:0] v;
    reset_n  = 1'b0;
    cfg_lock = 1'b0;
    v0 = 0; v1 = 0; w0 = 0; w1 = 0;
    a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      stub_mem[i] = v;
      ref_mem[i]  = v;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // single write then readback
    issue(0, 1'b1, 8'd3, 8'hA5);
    issue(0, 1'b0, 8'd3, 8'h00);

    // contention: both requesters hold reads of 1 and 2 back-to-back
    fork
      begin for (int k = 0; k < 4; k++) issue(0, 1'b0, 8'd1, 8'h00); end
      begin for (int k = 0; k < 4; k++) issue(1, 1'b0, 8'd2, 8'h00); end
    join

    // out-of-range and boundary addresses
    issue(1, 1'b0, 8'd6, 8'h00);
    issue(0, 1'b1, 8'd255, 8'h33);
    issue(1, 1'b0, 8'd5, 8'h00);
    issue(1, 1'b1, 8'd5, 8'h77);
    issue(0, 1'b0, 8'd5, 8'h00);

    // requester 1 arrives while requester 0's read is in flight
    fork
      issue(0, 1'b0, 8'd1, 8'h00);
      begin idle_cycles(1); issue(1, 1'b0, 8'd2, 8'h00); end
    join

    // reset in RDWAIT; afterwards both valid and requester 0 must win
    idle_cycles(2);
    issue(0, 1'b0, 8'd4, 8'h00);
    idle_cycles(1);
    reset_n = 1'b0;
    idle_cycles(2);
    fork
      issue(0, 1'b0, 8'd0, 8'h00);
      issue(1, 1'b0, 8'd3, 8'h00);
      begin idle_cycles(1); reset_n = 1'b1; end
    join

`ifdef REGFILE_ARB_LOCK_EN
    cfg_lock = 1'b1;
    issue(0, 1'b1, 8'd2, 8'h5A);
    issue(0, 1'b0, 8'd2, 8'h00);
    issue(1, 1'b1, 8'd2, 8'h5A);
    issue(0, 1'b0, 8'd2, 8'h00);
    cfg_lock = 1'b0;
`endif

    fork
      random_traffic(0, 25);
      random_traffic(1, 25);
    join

    idle_cycles(10);
    checks++;
    if (rsp_q.size() != 0 || strb_q.size() != 0) begin
      errors++;
      $display("FAIL drain rsp_left=%0d strb_left=%0d exp=0", rsp_q.size(), strb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
